// File: rtl/bitline_pkg.sv
// bitline_pkg: shared BITLINE frame definitions for transmitter and receiver
package bitline_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_GAP
  } state_e;
  localparam logic LINE_IDLE = 1'b0;
  localparam logic LINE_PRE = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP = 1'b0;
  localparam int NBITS_DEFAULT = 8;
  function automatic int max_of(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/bitline_shifter.sv
// bitline_shifter: parallel-load left-shift register exposing the MSB it will hold next cycle
module bitline_shifter import bitline_pkg::*; #(
  parameter int NBITS = NBITS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [NBITS-1:0] din,
  output logic             next_msb
);
  logic [NBITS-1:0] sh_q, sh_d;
  // load wins over shift; shifting zero-fills from the right
  always_comb sh_d = load ? din : shift ? sh_q << 1 : sh_q;
  assign next_msb = sh_d[NBITS-1];
  // shift register state
  always_ff @(posedge clk) sh_q <= rst ? '0 : sh_d;
endmodule

// File: rtl/serial_bit_tx.sv
// serial_bit_tx: BITLINE frame transmitter (preamble, start, data MSB-first, stop, optional gap)
module serial_bit_tx import bitline_pkg::*; #(
  parameter int NBITS           = NBITS_DEFAULT,
  parameter int PREAMBLE_CYCLES = 1,
  parameter int GAP_CYCLES      = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WREN,
  input  logic [NBITS-1:0] WDATA,
  output logic             READY,
  output logic             BITLINE,
  output logic             BUSY
);
  localparam int CW = $clog2(max_of(max_of(NBITS, PREAMBLE_CYCLES), max_of(GAP_CYCLES, 2)));
  localparam logic [CW-1:0] PRE_LAST = CW'(PREAMBLE_CYCLES - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(NBITS - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic bit_q, bit_d, busy_q, busy_d, xfer, next_msb;
  assign READY = state_q == ST_IDLE || (GAP_CYCLES == 0 && state_q == ST_STOP);
  assign xfer = WREN & READY;
  assign BITLINE = bit_q;
  assign BUSY = busy_q;
  bitline_shifter #(.NBITS(NBITS)) u_shift (
    .clk     (CLK),
    .rst     (RST),
    .load    (xfer),
    .shift   (state_q == ST_DATA),
    .din     (WDATA),
    .next_msb(next_msb)
  );
  // next state and counter; STOP chains straight into PREAMBLE when no gap is configured
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      ST_IDLE: begin
        state_d = xfer ? ST_PRE : ST_IDLE;
        cnt_d = '0;
      end
      ST_PRE: begin
        state_d = cnt_q == PRE_LAST ? ST_START : ST_PRE;
        cnt_d = cnt_q == PRE_LAST ? '0 : cnt_q + CW'(1);
      end
      ST_START: begin
        state_d = ST_DATA;
        cnt_d = '0;
      end
      ST_DATA: begin
        state_d = cnt_q == DATA_LAST ? ST_STOP : ST_DATA;
        cnt_d = cnt_q == DATA_LAST ? cnt_q : cnt_q + CW'(1);
      end
      ST_STOP: begin
        state_d = GAP_CYCLES > 0 ? ST_GAP : xfer ? ST_PRE : ST_IDLE;
        cnt_d = '0;
      end
      ST_GAP: begin
        state_d = cnt_q == GAP_LAST ? ST_IDLE : ST_GAP;
        cnt_d = cnt_q == GAP_LAST ? '0 : cnt_q + CW'(1);
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d = '0;
      end
    endcase
  end
  // line level and busy flag for the upcoming state, so both come straight from flops
  always_comb begin
    bit_d = state_d == ST_PRE   ? LINE_PRE :
            state_d == ST_DATA  ? next_msb :
            state_d == ST_START ? LINE_START :
            state_d == ST_STOP  ? LINE_STOP : LINE_IDLE;
    busy_d = state_d != ST_IDLE;
  end
  // FSM, counter and registered outputs; reset drops any frame in flight
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      bit_q <= LINE_IDLE;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      busy_q <= busy_d;
    end
  end
endmodule

// File: tb/tb_serial_bit_tx.sv
// tb_serial_bit_tx: directed bench with line-level checks and a frame-decoding scoreboard
module tb_serial_bit_tx;
  logic clk, rst;
  logic wren0, ready0, bl0, busy0;
  logic [7:0] wdata0;
  logic wren1, ready1, bl1, busy1;
  logic [7:0] wdata1;
  int total, bad, rx_n, rs, rn;
  logic [7:0] rsh;
  logic [7:0] sb[$];

  serial_bit_tx dut0 (
    .CLK(clk), .RST(rst), .WREN(wren0), .WDATA(wdata0),
    .READY(ready0), .BITLINE(bl0), .BUSY(busy0)
  );
  serial_bit_tx #(.GAP_CYCLES(3)) dut1 (
    .CLK(clk), .RST(rst), .WREN(wren1), .WDATA(wdata1),
    .READY(ready1), .BITLINE(bl1), .BUSY(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic fb(input logic [7:0] d, input int j);
    return j == 0 ? 1'b1 : (j >= 2 && j <= 9) ? d[9-j] : 1'b0;
  endfunction

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic send0(input logic [7:0] d);
    int k = 0;
    wren0 = 1'b1;
    wdata0 = d;
    while (!ready0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("send_ready", ready0, 1);
    @(negedge clk);
    sb.push_back(d);
    wren0 = 1'b0;
  endtask

  // independent receiver model decoding dut0's line into bytes
  always @(posedge clk) begin
    #2;
    if (rst) rs = 0;
    else case (rs)
      0: if (bl0) rs = 1;
      1: if (!bl0) begin rs = 2; rn = 0; end
      2: begin
        rsh = {rsh[6:0], bl0};
        rn++;
        if (rn == 8) rs = 3;
      end
      default: begin
        chk("rx_stop", bl0, 0);
        chk("rx_have_exp", sb.size() != 0, 1);
        if (sb.size() != 0) chk("rx_data", rsh, sb.pop_front());
        rx_n++;
        rs = 0;
      end
    endcase
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] lb[4];
    lb[0] = 8'h00; lb[1] = 8'h80; lb[2] = 8'h01; lb[3] = 8'hFF;
    rst = 1'b1; wren0 = 1'b0; wdata0 = 8'h00; wren1 = 1'b0; wdata1 = 8'h00;
    total = 0; bad = 0; rx_n = 0; rs = 0; rn = 0; rsh = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_line", bl0, 0);
    chk("rst_ready", ready0, 1);
    chk("rst_busy", busy0, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_line", bl0, 0);
      chk("idle_ready", ready0, 1);
      chk("idle_busy", busy0, 0);
    end
    wren0 = 1'b1; wdata0 = 8'hA5;
    chk("a5_ready0", ready0, 1);
    @(negedge clk);
    wren0 = 1'b0;
    sb.push_back(8'hA5);
    for (int i = 0; i < 11; i++) begin
      chk("a5_line", bl0, fb(8'hA5, i));
      chk("a5_ready", ready0, i == 10);
      chk("a5_busy", busy0, 1);
      wdata0 = 8'($urandom);
      @(negedge clk);
    end
    chk("a5_end_line", bl0, 0);
    chk("a5_end_busy", busy0, 0);
    chk("a5_end_ready", ready0, 1);
    wren0 = 1'b1; wdata0 = 8'h3C;
    @(negedge clk);
    sb.push_back(8'h3C);
    wdata0 = 8'hFF;
    for (int i = 0; i < 22; i++) begin
      chk("b2b_line", bl0, i < 11 ? fb(8'h3C, i) : fb(8'hFF, i - 11));
      chk("b2b_ready", ready0, i == 10 || i == 21);
      chk("b2b_busy", busy0, 1);
      if (i == 10) sb.push_back(8'hFF);
      @(negedge clk);
      if (i == 10) wren0 = 1'b0;
    end
    chk("b2b_end_line", bl0, 0);
    chk("b2b_end_busy", busy0, 0);
    foreach (lb[i]) send0(lb[i]);
    repeat (14) @(negedge clk);
    chk("lb_drain", sb.size(), 0);
    chk("lb_count", rx_n, 7);
    send0(8'hA5);
    repeat (3) @(negedge clk);
    chk("mid_line", bl0, fb(8'hA5, 3));
    chk("mid_busy", busy0, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_line", bl0, 0);
    chk("mrst_ready", ready0, 1);
    chk("mrst_busy", busy0, 0);
    void'(sb.pop_front());
    rst = 1'b1; wren0 = 1'b1; wdata0 = 8'h77;
    @(negedge clk);
    rst = 1'b0; wren0 = 1'b0;
    chk("rw_busy", busy0, 0);
    chk("rw_line", bl0, 0);
    @(negedge clk);
    chk("rw_line2", bl0, 0);
    chk("rw_busy2", busy0, 0);
    send0(8'h5A);
    repeat (14) @(negedge clk);
    chk("5a_drain", sb.size(), 0);
    chk("5a_count", rx_n, 8);
    wren1 = 1'b1; wdata1 = 8'hC3;
    chk("gap_ready0", ready1, 1);
    @(negedge clk);
    wdata1 = 8'h96;
    for (int i = 0; i < 26; i++) begin
      chk("gap_line", bl1, i < 11 ? fb(8'hC3, i) : i < 15 ? 1'b0 : fb(8'h96, i - 15));
      chk("gap_ready", ready1, i == 14);
      chk("gap_busy", busy1, i != 14);
      @(negedge clk);
      if (i == 14) wren1 = 1'b0;
    end
    chk("gap2_line", bl1, 0);
    chk("gap2_busy", busy1, 1);
    chk("gap2_ready", ready1, 0);
    repeat (3) @(negedge clk);
    chk("gap_idle_busy", busy1, 0);
    chk("gap_idle_ready", ready1, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
